// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: S-box, Rcon, key-length decode and FSM state type.
package aes_pkg;

  localparam logic [1:0] KEY_LEN_128 = 2'd0;
  localparam logic [1:0] KEY_LEN_192 = 2'd1;
  localparam logic [1:0] KEY_LEN_256 = 2'd2;
  localparam logic [1:0] KEY_LEN_BAD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GEN,
    ST_OUT
  } ks_state_t;

  // Which temp transform applies to w[i-1] when deriving w[i].
  typedef enum logic [1:0] {
    PH_PLAIN,
    PH_ROT_SUB,
    PH_SUB
  } word_phase_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:9][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Rcon is 1-based (Rcon[1] = 01); index 0 never reaches a rot/sub word.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [3:0] pos;
    pos = idx - 4'd1;
    if (idx >= 4'd1 && idx <= 4'd10) return RCON[pos];
    return 8'h00;
  endfunction

  function automatic logic [3:0] nk_of(input logic [1:0] key_len);
    case (key_len)
      KEY_LEN_192: return 4'd6;
      KEY_LEN_256: return 4'd8;
      default:     return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] key_len);
    case (key_len)
      KEY_LEN_192: return 4'd12;
      KEY_LEN_256: return 4'd14;
      default:     return 4'd10;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_word.sv
// One step of the key recurrence: w[i] = w[i-Nk] ^ temp(w[i-1]).
module aes_key_word
  import aes_pkg::*;
(
  input  logic [31:0]  w_prev,
  input  logic [31:0]  w_back,
  input  word_phase_t  phase,
  input  logic [7:0]   rcon_byte,
  output logic [31:0]  w_next
);

  logic [31:0] temp;

  always_comb begin
    temp = w_prev;
    case (phase)
      PH_ROT_SUB: temp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon_byte, 24'h0};
      PH_SUB:     temp = sub_word(w_prev);
      default:    temp = w_prev;
    endcase
  end

  assign w_next = w_back ^ temp;

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES-128/192/256 key expansion: one schedule word per cycle, 4-word round keys
// handed out over a valid/ready handshake.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int KEY_W = 256,
  parameter int RK_W  = 128,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       key_len,
  input  logic [KEY_W-1:0] key,
  output logic             busy,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [RK_W-1:0]  round_key,
  output logic [3:0]       rk_index,
  output logic             done,
  output logic             err
);

  ks_state_t         state_reg, state_next;
  logic [KEY_W-1:0]  key_reg;
  logic [3:0]        nk_reg, nr_reg;
  logic [CNT_W-1:0]  i_reg;
  logic [2:0]        mod_reg;
  logic [3:0]        rcon_idx_reg;
  logic [31:0]       hist_reg [0:7];
  logic [RK_W-1:0]   out_buf_reg;
  logic [1:0]        pos_reg;
  logic [3:0]        rk_index_reg;
  logic              done_reg, err_reg;

  logic              start_ok, start_bad, gen_step, rk_advance, last_hs;
  logic [31:0]       key_words [0:7];
  logic [2:0]        back_sel;
  logic              in_key;
  word_phase_t       phase;
  logic [31:0]       w_derived, w_cur;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_key_words
      assign key_words[gi] = key_reg[KEY_W-1-32*gi -: 32];
    end
  endgenerate

  // hist_reg[k] holds w[i-1-k], so w[i-Nk] sits at Nk-1.
  assign back_sel = 3'(nk_reg - 4'd1);
  assign in_key   = i_reg < CNT_W'(nk_reg);

  always_comb begin
    phase = PH_PLAIN;
    if (mod_reg == 3'd0)
      phase = PH_ROT_SUB;
    else if (nk_reg == 4'd8 && mod_reg == 3'd4)
      phase = PH_SUB;
  end

  aes_key_word u_key_word (
    .w_prev    (hist_reg[0]),
    .w_back    (hist_reg[back_sel]),
    .phase     (phase),
    .rcon_byte (rcon(rcon_idx_reg)),
    .w_next    (w_derived)
  );

  assign w_cur = in_key ? key_words[i_reg[2:0]] : w_derived;

  always_comb begin
    state_next = state_reg;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    gen_step   = 1'b0;
    rk_advance = 1'b0;
    last_hs    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (key_len == KEY_LEN_BAD) begin
            start_bad = 1'b1;
          end else begin
            start_ok   = 1'b1;
            state_next = ST_GEN;
          end
        end
      end
      ST_GEN: begin
        gen_step = 1'b1;
        if (pos_reg == 2'd3) state_next = ST_OUT;
      end
      ST_OUT: begin
        if (rk_ready) begin
          if (rk_index_reg == nr_reg) begin
            last_hs    = 1'b1;
            state_next = ST_IDLE;
          end else begin
            rk_advance = 1'b1;
            state_next = ST_GEN;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      key_reg      <= '0;
      nk_reg       <= '0;
      nr_reg       <= '0;
      i_reg        <= '0;
      mod_reg      <= '0;
      rcon_idx_reg <= '0;
      out_buf_reg  <= '0;
      pos_reg      <= '0;
      rk_index_reg <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      for (int k = 0; k < 8; k++) hist_reg[k] <= '0;
    end else begin
      state_reg <= state_next;
      done_reg  <= last_hs;
      err_reg   <= start_bad;
      if (start_ok) begin
        key_reg      <= key;
        nk_reg       <= nk_of(key_len);
        nr_reg       <= nr_of(key_len);
        i_reg        <= '0;
        mod_reg      <= '0;
        rcon_idx_reg <= '0;
        pos_reg      <= '0;
        rk_index_reg <= '0;
      end
      if (gen_step) begin
        hist_reg[0] <= w_cur;
        for (int k = 1; k < 8; k++) hist_reg[k] <= hist_reg[k-1];
        out_buf_reg <= {out_buf_reg[RK_W-33:0], w_cur};
        i_reg       <= i_reg + 1'b1;
        pos_reg     <= pos_reg + 2'd1;
        // i mod Nk and i/Nk without a divider
        if (mod_reg == 3'(nk_reg - 4'd1)) begin
          mod_reg      <= '0;
          rcon_idx_reg <= rcon_idx_reg + 4'd1;
        end else begin
          mod_reg <= mod_reg + 3'd1;
        end
      end
      if (rk_advance) rk_index_reg <= rk_index_reg + 4'd1;
    end
  end

  assign busy      = (state_reg != ST_IDLE);
  assign rk_valid  = (state_reg == ST_OUT);
  assign round_key = out_buf_reg;
  assign rk_index  = rk_index_reg;
  assign done      = done_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench: FIPS-197 style expansion model (S-box derived from GF(2^8)) plus cycle timing model.
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   key_len = 2'd0;
  logic [255:0] key = '0;
  logic         rk_ready = 1'b0;
  logic         busy, rk_valid, done, err;
  logic [127:0] round_key;
  logic [3:0]   rk_index;

  aes_key_schedule dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key(key),
    .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready), .round_key(round_key),
    .rk_index(rk_index), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]   tb_sbox [256];
  logic [127:0] m_keys [15];
  int           m_nr = 0;
  bit           m_busy = 0;
  int           m_wait = 0;
  int           m_r = 0;
  bit           m_done_exp = 0;
  bit           m_err_exp = 0;
  bit           m_rst_seen = 1;
  logic [127:0] dut_log [16];
  int           log_cnt = 0;
  bit           prev_stall = 0;
  logic [127:0] prev_rk = '0;
  logic [3:0]   prev_idx = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int n = 0; n < 8; n++) begin
      if (y[0]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      tb_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] tb_sub(input logic [31:0] w);
    return {tb_sbox[w[31:24]], tb_sbox[w[23:16]], tb_sbox[w[15:8]], tb_sbox[w[7:0]]};
  endfunction

  function automatic logic [7:0] rc_pow(input int j);
    logic [7:0] r = 8'h01;
    for (int n = 1; n < j; n++) r = gmul(r, 8'h02);
    return r;
  endfunction

  task automatic model_expand(input logic [1:0] len, input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] t;
    int nk = 4 + 2 * int'(len);
    m_nr = nk + 6;
    for (int i = 0; i < 4 * (m_nr + 1); i++) begin
      if (i < nk) begin
        w[i] = k[255 - 32 * i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) t = tb_sub({t[23:0], t[31:24]}) ^ {rc_pow(i / nk), 24'h0};
        else if (nk == 8 && i % nk == 4) t = tb_sub(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= m_nr; r++) m_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Compare process: check this cycle's outputs, then predict the next edge from sampled inputs.
  always @(negedge clk) begin
    bit exp_valid;
    exp_valid = m_busy && (m_wait == 0);
    chk("busy", 128'(busy), 128'(m_busy));
    chk("rk_valid", 128'(rk_valid), 128'(exp_valid));
    chk("done", 128'(done), 128'(m_done_exp));
    chk("err", 128'(err), 128'(m_err_exp));
    if (exp_valid) begin
      chk("rk_index", 128'(rk_index), 128'(m_r));
      chk("round_key", round_key, m_keys[m_r]);
    end
    if (m_rst_seen) begin
      chk("rst_round_key", round_key, 128'h0);
      chk("rst_rk_index", 128'(rk_index), 128'h0);
    end
    if (prev_stall && rk_valid) begin
      chk("stall_key", round_key, prev_rk);
      chk("stall_index", 128'(rk_index), 128'(prev_idx));
    end
    prev_stall = rk_valid && !rk_ready && rst;
    prev_rk    = round_key;
    prev_idx   = rk_index;
    if (rk_valid && rk_ready && rst) begin
      dut_log[rk_index] = round_key;
      log_cnt++;
      $display("handshake rk%0d = %h", rk_index, round_key);
    end

    m_done_exp = 0;
    m_err_exp  = 0;
    m_rst_seen = 0;
    if (!rst) begin
      m_busy     = 0;
      m_rst_seen = 1;
    end else if (!m_busy) begin
      if (start) begin
        if (key_len == 2'd3) begin
          m_err_exp = 1;
        end else begin
          model_expand(key_len, key);
          m_busy = 1;
          m_wait = 4;
          m_r    = 0;
        end
      end
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (rk_ready) begin
      if (m_r == m_nr) begin
        m_busy     = 0;
        m_done_exp = 1;
      end else begin
        m_r++;
        m_wait = 4;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic issue_start(input logic [1:0] len, input logic [255:0] k, input int duty);
    start    = 1'b1;
    key_len  = len;
    key      = k;
    rk_ready = ($urandom_range(99) < duty);
    tick();
    start   = 1'b0;
    key     = rand_key();
    key_len = 2'($urandom_range(3));
  endtask

  task automatic wait_done(input int duty, input bit spam, input bit chain,
                           input logic [1:0] chain_len, input logic [255:0] chain_key);
    bit got = 0;
    for (int c = 0; c < 2000 && !got; c++) begin
      rk_ready = ($urandom_range(99) < duty);
      if (spam) begin
        start   = 1'($urandom_range(1));
        key_len = 2'($urandom_range(3));
        key     = rand_key();
      end
      tick();
      if (done) begin
        got      = 1;
        rk_ready = 1'b0;
        if (chain) begin
          start   = 1'b1;
          key_len = chain_len;
          key     = chain_key;
        end else begin
          start = 1'b0;
        end
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout actual=no_done required=done_within_2000_cycles");
    end
    if (chain) begin
      tick();
      start = 1'b0;
    end
  endtask

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0123456789abcdeffedcba9876543210};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hcafef00d12345678};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    int base;
    build_sbox();
    chk("model_sbox_00", 128'(tb_sbox[0]), 128'h63);
    chk("model_sbox_53", 128'(tb_sbox[8'h53]), 128'hed);
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // AES-128 known-answer, ready held high
    base = log_cnt;
    issue_start(2'd0, K128, 100);
    wait_done(100, 0, 0, 2'd0, '0);
    chk("aes128_count", 128'(log_cnt - base), 128'd11);
    chk("aes128_rk0", dut_log[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("aes128_rk1", dut_log[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("aes128_rk10", dut_log[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // AES-192, chained straight into AES-256 in the done cycle
    base = log_cnt;
    issue_start(2'd1, K192, 100);
    wait_done(100, 0, 1, 2'd2, K256);
    chk("aes192_count", 128'(log_cnt - base), 128'd13);
    chk("aes192_w51", 128'(dut_log[12][31:0]), 128'h01002202);
    base = log_cnt;
    wait_done(100, 0, 0, 2'd0, '0);
    chk("aes256_count", 128'(log_cnt - base), 128'd15);
    chk("aes256_w59", 128'(dut_log[14][31:0]), 128'h706c631e);

    // Backpressure at 30% ready with start spammed while busy
    base = log_cnt;
    issue_start(2'd0, K128, 30);
    wait_done(30, 1, 0, 2'd0, '0);
    chk("bp_count", 128'(log_cnt - base), 128'd11);
    chk("bp_rk1", dut_log[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("bp_rk10", dut_log[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Illegal key length
    tick();
    start   = 1'b1;
    key_len = 2'd3;
    tick();
    start = 1'b0;
    chk("err_pulse", 128'(err), 128'd1);
    chk("err_busy", 128'(busy), 128'd0);
    tick();
    chk("err_single", 128'(err), 128'd0);

    // Reset while generating rk5, then a clean run
    issue_start(2'd0, K128, 100);
    rk_ready = 1'b1;
    for (int c = 0; c < 200 && !(busy && !rk_valid && rk_index == 4'd5); c++) tick();
    chk("rst_reached_rk5", 128'(rk_index), 128'd5);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    rk_ready = 1'b0;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_valid", 128'(rk_valid), 128'd0);
    tick();
    base = log_cnt;
    issue_start(2'd0, K128, 100);
    wait_done(100, 0, 0, 2'd0, '0);
    chk("post_rst_count", 128'(log_cnt - base), 128'd11);
    chk("post_rst_rk10", dut_log[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Random keys and lengths with random backpressure
    for (int n = 0; n < 6; n++) begin
      logic [1:0] len;
      int duty;
      len  = 2'($urandom_range(2));
      duty = 20 + $urandom_range(80);
      base = log_cnt;
      issue_start(len, rand_key(), duty);
      wait_done(duty, n[0], 0, 2'd0, '0);
      chk("rand_count", 128'(log_cnt - base), 128'(4 + 2 * int'(len) + 7));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
- Sequential AES round-key generator supporting AES-128, AES-192 and AES-256, selected per operation.
- Produces one 32-bit schedule word per cycle and groups every 4 words into a 128-bit round key.
- Presents each round key on a valid/ready handshake, in order from round key 0 up to Nr.
- Sits between the key register and the round datapath, replacing the fixed 128-bit single-round key expansion.

Parameters:
- KEY_W, 256, width of key input; key is left-aligned, so key[255:224] is word w0.
- RK_W, 128, round-key width; fixed to 4 words, other values unsupported.
- CNT_W, 6, width of the word counter; must hold 0..59.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- start  in  1  begin an expansion; accepted only in IDLE.
- key_len  in  2  0 = 128-bit (Nk=4, Nr=10), 1 = 192-bit (Nk=6, Nr=12), 2 = 256-bit (Nk=8, Nr=14), 3 = illegal.
- key  in  KEY_W  cipher key, left-aligned; unused low bits are ignored.
- busy  out  1  high in every state except IDLE.
- rk_valid  out  1  round_key is valid.
- rk_ready  in  1  consumer accepts round_key.
- round_key  out  RK_W  w[4r] in bits [127:96], w[4r+1] in [95:64], w[4r+2] in [63:32], w[4r+3] in [31:0].
- rk_index  out  4  round number r of round_key.
- done  out  1  one-cycle pulse after the final round key is accepted.
- err  out  1  one-cycle pulse when start arrives with key_len = 3.

Behaviour:
- Reset: rst low at a clock edge forces state IDLE and clears all counters and word buffers. All outputs are 0 after that edge. This holds in any state, including mid-expansion.
- States:
  - IDLE: start=1 and key_len≠3 → capture key and Nk/Nr, clear i, rk_index and rcon index, go to GEN. start=1 and key_len=3 → pulse err, stay in IDLE.
  - GEN: each cycle compute w[i], shift it into an 8-word history window and a 4-word output buffer, then i += 1. When the 4th word of the group is written, go to OUT.
  - OUT: rk_valid=1; round_key and rk_index are held stable until rk_ready=1.
    - On handshake with rk_index = Nr: go to IDLE and pulse done in the following cycle.
    - On handshake otherwise: rk_index += 1, go to GEN.
- Word rule:
  - i < Nk: w[i] is key word i.
  - i ≥ Nk: w[i] = w[i-Nk] ^ temp, where temp is:
    - i mod Nk == 0: SubWord(RotWord(w[i-1])) ^ {Rcon[i/Nk], 24'h0}.
    - Nk == 8 and i mod Nk == 4: SubWord(w[i-1]).
    - otherwise: w[i-1].
  - i mod Nk and i/Nk are tracked with a wrap counter and a Rcon index counter. No divider.
- Totals: 44, 52 or 60 words, giving 11, 13 or 15 round keys.
- Latency:
  - start accepted at edge E0: GEN runs E1..E4, rk_valid=1 in the cycle after E4.
  - Each following key takes 4 cycles after the accepting handshake.
  - With rk_ready held high, 5 cycles per round key.
- start while busy is ignored; key and key_len are not re-sampled mid-operation.
- The key input may change freely after acceptance.
- rk_ready while rk_valid=0 has no effect.
- done and start in the same cycle: done pulses while the FSM is already in IDLE, so start is accepted normally.

Decomposition:
- Shared package aes_pkg:
  - 256-entry S-box function.
  - Rcon table (01,02,04,08,10,20,40,80,1b,36).
  - Nk/Nr lookup from key_len.
  - KEY_LEN_* constants.
  - FSM state enum.
- One sub-module, aes_key_word: combinational RotWord/SubWord/Rcon/XOR. Inputs are w[i-1], w[i-Nk], phase select and Rcon; output is w[i].

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 → rk0 = key; rk1 = a0fafe1788542cb123a339392a6c7605; rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6; done one cycle after the rk10 handshake; 11 keys total.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → 13 keys; rk12[31:0] = w51 = 01002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → 15 keys; rk14[31:0] = w59 = 706c631e.
- Backpressure: rk_ready random 30% duty → round_key and rk_index stable while stalled; same values as the first scenario.
- start with key_len=3 → err pulses one cycle, busy stays 0. Repeated start while busy → ignored, sequence unchanged.
- rst driven low during GEN of rk5 → all outputs 0 next cycle. Next start gives a clean rk0..rk10 sequence.
